// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the multi-bus round-robin arbiter.
package bus_arb_pkg;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned IDX_W     = ID_W + 1;
    localparam int unsigned MAX_DRV   = 256;
    localparam int unsigned MAX_PKT_W = 1024;
    localparam int unsigned ERR_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } lane_state_e;

    // Destination ID lives in the top ID_W bits of a w-bit packet.
    function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                                 input int unsigned w);
        return ID_W'(pkt >> (w - ID_W));
    endfunction

    // First requester after ptr, wrapping at n; returns ptr when nothing is pending.
    function automatic logic [ID_W-1:0] rr_pick(input logic [MAX_DRV-1:0] req,
                                                input logic [ID_W-1:0]    ptr,
                                                input logic [ID_W-1:0]    n);
        logic [IDX_W-1:0] idx;
        logic [ID_W-1:0]  pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_DRV; i++) begin
            idx = {1'b0, ptr} + IDX_W'(i);
            if (idx >= {1'b0, n}) begin
                idx = idx - {1'b0, n};
            end
            if (!found && (IDX_W'(i) <= {1'b0, n}) && req[idx[ID_W-1:0]]) begin
                pick  = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_arb_lane.sv
// One bus lane: round-robin grant, pop one packet, decode and push it.
// Optional drop counter enabled by BUS_ARB_ERR_CNT_EN.
module bus_arb_lane
    import bus_arb_pkg::*;
#(
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              data,
    output logic                            busy
`ifdef BUS_ARB_ERR_CNT_EN
    ,
    output logic [ERR_W-1:0]                err_cnt,
    output logic                            err_flag
`endif
);

    lane_state_e          state_q, state_n;
    logic [ID_W-1:0]      ptr_q, ptr_n;
    logic [ID_W-1:0]      src_q, src_n;
    logic [pckg_sz-1:0]   data_q, data_n;
    logic [drvrs-1:0]     pop_q, pop_n;
    logic [drvrs-1:0]     push_q, push_n;
    logic                 busy_q;
    logic [ID_W-1:0]      grant;
    logic [ID_W-1:0]      dest;
    logic [pckg_sz-1:0]   cur;
`ifdef BUS_ARB_ERR_CNT_EN
    logic                 drop_n;
    logic [ERR_W-1:0]     err_cnt_q;
    logic                 err_flag_q;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        src_n   = src_q;
        data_n  = data_q;
        pop_n   = '0;
        push_n  = '0;
        grant   = '0;
        dest    = '0;
        cur     = '0;
`ifdef BUS_ARB_ERR_CNT_EN
        drop_n  = 1'b0;
`endif
        for (int unsigned i = 0; i < drvrs; i++) begin
            if (ID_W'(i) == src_q) begin
                cur = d_pop[i];
            end
        end
        case (state_q)
            IDLE: begin
                if (|pndng) begin
                    grant   = rr_pick(MAX_DRV'(pndng), ptr_q, ID_W'(drvrs));
                    src_n   = grant;
                    ptr_n   = grant;
                    state_n = POP;
                    for (int unsigned i = 0; i < drvrs; i++) begin
                        pop_n[i] = (ID_W'(i) == grant);
                    end
                end
            end
            POP: begin
                data_n = cur;
                dest   = get_dest(MAX_PKT_W'(cur), pckg_sz);
                // Broadcast skips the source; unicast may target the source itself.
                for (int unsigned i = 0; i < drvrs; i++) begin
                    if (dest == broadcast) begin
                        push_n[i] = (ID_W'(i) != src_q);
                    end else begin
                        push_n[i] = (dest == ID_W'(i));
                    end
                end
`ifdef BUS_ARB_ERR_CNT_EN
                drop_n = (dest != broadcast) && (dest >= ID_W'(drvrs));
`endif
                state_n = PUSH;
            end
            PUSH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(drvrs - 1);
            src_q   <= '0;
            data_q  <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            src_q   <= src_n;
            data_q  <= data_n;
            pop_q   <= pop_n;
            push_q  <= push_n;
            busy_q  <= (state_n != IDLE);
        end
    end

`ifdef BUS_ARB_ERR_CNT_EN
    // Saturating drop counter and sticky flag, updated as the lane enters PUSH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else if (drop_n) begin
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
            err_flag_q <= 1'b1;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_flag = err_flag_q;
`endif

    assign pop  = pop_q;
    assign push = push_q;
    assign data = data_q;
    assign busy = busy_q;

endmodule

// File: rtl/bus_arb_rr_mb.sv
// Multi-bus round-robin bus generator/arbiter: `bits` independent lanes of `drvrs` drivers.
// BUS_ARB_ERR_CNT_EN adds per-lane err_cnt/err_flag drop reporting.
module bus_arb_rr_mb
    import bus_arb_pkg::*;
#(
    parameter int unsigned     bits      = 1,
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [bits*drvrs-1:0]             pndng,
    input  logic [bits*drvrs*pckg_sz-1:0]     D_pop,
    output logic [bits*drvrs-1:0]             pop,
    output logic [bits*drvrs-1:0]             push,
    output logic [bits*drvrs*pckg_sz-1:0]     D_push,
    output logic [bits-1:0]                   busy
`ifdef BUS_ARB_ERR_CNT_EN
    ,
    output logic [bits*ERR_W-1:0]             err_cnt,
    output logic [bits-1:0]                   err_flag
`endif
);

    for (genvar l = 0; l < bits; l++) begin : g_lane
        logic [pckg_sz-1:0] lane_data;

`ifdef BUS_ARB_ERR_CNT_EN
        bus_arb_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .pndng    (pndng[l*drvrs +: drvrs]),
            .d_pop    (D_pop[l*drvrs*pckg_sz +: drvrs*pckg_sz]),
            .pop      (pop[l*drvrs +: drvrs]),
            .push     (push[l*drvrs +: drvrs]),
            .data     (lane_data),
            .busy     (busy[l]),
            .err_cnt  (err_cnt[l*ERR_W +: ERR_W]),
            .err_flag (err_flag[l])
        );
`else
        bus_arb_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .pndng    (pndng[l*drvrs +: drvrs]),
            .d_pop    (D_pop[l*drvrs*pckg_sz +: drvrs*pckg_sz]),
            .pop      (pop[l*drvrs +: drvrs]),
            .push     (push[l*drvrs +: drvrs]),
            .data     (lane_data),
            .busy     (busy[l])
        );
`endif

        // Every driver on a lane sees the same held packet.
        for (genvar d = 0; d < drvrs; d++) begin : g_drv
            assign D_push[(l*drvrs+d)*pckg_sz +: pckg_sz] = lane_data;
        end
    end

endmodule

// File: tb/tb_bus_arb_rr_mb.sv
// Directed bench for bus_arb_rr_mb with two lanes of four 16-bit drivers.
module tb_bus_arb_rr_mb;

    localparam int unsigned BITS  = 2;
    localparam int unsigned DRV   = 4;
    localparam int unsigned PW    = 16;
    localparam int unsigned LANEW = DRV * PW;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [BITS*DRV-1:0]       pndng;
    logic [BITS*DRV*PW-1:0]    D_pop;
    logic [BITS*DRV-1:0]       pop;
    logic [BITS*DRV-1:0]       push;
    logic [BITS*DRV*PW-1:0]    D_push;
    logic [BITS-1:0]           busy;
`ifdef BUS_ARB_ERR_CNT_EN
    logic [BITS*16-1:0]        err_cnt;
    logic [BITS-1:0]           err_flag;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    bus_arb_rr_mb #(
        .bits      (BITS),
        .drvrs     (DRV),
        .pckg_sz   (PW),
        .broadcast (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy)
`ifdef BUS_ARB_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt),
        .err_flag (err_flag)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One packet on one lane/driver: pop next cycle, push the cycle after, then idle.
    task automatic xfer(input string tag, input int lane, input int drv,
                        input logic [15:0] data, input logic [3:0] exp_push);
        logic [7:0] exp8;
        pndng = '0;
        pndng[lane*DRV+drv] = 1'b1;
        D_pop[(lane*DRV+drv)*PW +: PW] = data;
        tick();
        exp8 = 8'h01 << (lane*DRV + drv);
        check({tag, "_pop"}, 64'(pop), 64'(exp8));
        check({tag, "_busy"}, 64'(busy), 64'(2'b01 << lane));
        pndng = '0;
        tick();
        exp8 = 8'({4'b0, exp_push} << (lane*DRV));
        check({tag, "_push"}, 64'(push), 64'(exp8));
        check({tag, "_dpush"}, D_push[lane*LANEW +: LANEW], {4{data}});
        check({tag, "_popoff"}, 64'(pop), 64'(0));
        tick();
        check({tag, "_pushoff"}, 64'(push), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
        check({tag, "_hold"}, D_push[lane*LANEW +: LANEW], {4{data}});
    endtask

    initial begin
        logic [15:0] d;
        int          last_push;
        int          k;

        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        repeat (2) tick();
        check("rst_pop",   64'(pop),  64'(0));
        check("rst_push",  64'(push), 64'(0));
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_dpush", D_push[63:0], 64'(0));
        reset = 1'b1;
        tick();

        xfer("uni",      0, 1, 16'h0255, 4'b0100);
        xfer("bcast",    0, 3, 16'hFF12, 4'b0111);
        xfer("self",     0, 2, 16'h02AA, 4'b0100);
        xfer("dest_max", 0, 0, 16'h03C3, 4'b1000);
        xfer("bad7",     0, 0, 16'h0711, 4'b0000);
`ifdef BUS_ARB_ERR_CNT_EN
        check("err_cnt1",  64'(err_cnt[15:0]), 64'(1));
        check("err_flag1", 64'(err_flag[0]),   64'(1));
`endif
        xfer("bad4",     0, 1, 16'h0499, 4'b0000);
`ifdef BUS_ARB_ERR_CNT_EN
        check("err_cnt2",  64'(err_cnt[15:0]), 64'(2));
        check("err_lane1", 64'(err_cnt[31:16]), 64'(0));
`endif
        xfer("bcast0",   0, 0, 16'hFF00, 4'b1110);

        // Reset while in POP abandons the transfer at once.
        pndng[2] = 1'b1;
        D_pop[2*PW +: PW] = 16'h0133;
        tick();
        check("mid_pop", 64'(pop), 64'(8'b0000_0100));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pop",   64'(pop),  64'(0));
        check("mid_rst_push",  64'(push), 64'(0));
        check("mid_rst_busy",  64'(busy), 64'(0));
        check("mid_rst_dpush", D_push[63:0], 64'(0));
        pndng = '0;
        tick();
        reset = 1'b1;

        // All four pending: grants rotate 0,1,2,3 starting from driver 0.
        for (int i = 0; i < 4; i++) begin
            d = 16'(((i + 1) % 4) << 8) | 16'(8'hA0 + i);
            D_pop[i*PW +: PW] = d;
        end
        pndng = 8'h0F;
        last_push = 0;
        for (int p = 0; p < 12; p++) begin
            k = p % 4;
            tick();
            check("rr_pop", 64'(pop), 64'(8'h01 << k));
            tick();
            d = 16'(((k + 1) % 4) << 8) | 16'(8'hA0 + k);
            check("rr_push", 64'(push), 64'(8'h01 << ((k + 1) % 4)));
            check("rr_dpush", D_push[63:0], {4{d}});
            if (p > 0) begin
                check("rr_gap", 64'(cyc - last_push), 64'(3));
            end
            last_push = cyc;
            tick();
        end
        pndng = '0;
        tick();
        check("rr_done", 64'(busy), 64'(0));

        // Both lanes at once, different destinations.
        pndng = 8'b0100_0001;
        D_pop[0*PW +: PW]       = 16'h0101;
        D_pop[(DRV+2)*PW +: PW] = 16'h0302;
        tick();
        check("mb_pop",  64'(pop),  64'(8'b0100_0001));
        check("mb_busy", 64'(busy), 64'(2'b11));
        pndng = '0;
        tick();
        check("mb_push",  64'(push), 64'(8'b1000_0010));
        check("mb_d0",    D_push[63:0],   {4{16'h0101}});
        check("mb_d1",    D_push[127:64], {4{16'h0302}});
        tick();
        check("mb_idle", 64'(busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arb_rr_mb.md
Name: bus_arb_rr_mb

Overview:
- Parametrised successor to bs_gnrtr_n_rbtr: the bus generator/arbiter for the driver/monitor testbench environment.
- Generalised to `bits` independent buses, each shared by `drvrs` driver FIFOs.
- Per bus: round-robin arbitration among pending drivers, pop of one packet, destination decode from the packet header, push to one target or broadcast to all other drivers.
- Sits between the driver FIFOs (pndng/D_pop/pop) and the monitor FIFOs (push/D_push).

Parameters:
- bits, 1, number of independent buses (lanes).
- drvrs, 4, drivers per bus (2..254).
- pckg_sz, 16, packet width in bits (>= 9); bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- broadcast, 8'hFF, destination ID meaning "all drivers except the source".

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  bits*drvrs  FIFO non-empty flag per [bus][driver].
- D_pop  in  bits*drvrs*pckg_sz  head-of-FIFO data per [bus][driver], valid while pndng is high.
- pop  out  bits*drvrs  one-cycle pop strobe per [bus][driver].
- push  out  bits*drvrs  one-cycle push strobe per [bus][driver].
- D_push  out  bits*drvrs*pckg_sz  data accompanying push, per [bus][driver].
- busy  out  bits  lane is mid-transaction (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - pop, push, D_push, busy = 0.
  - Every lane FSM to IDLE.
  - Round-robin pointer = drvrs-1, so driver 0 wins first.
- Lane FSM states and transitions:
  - IDLE: if any pndng on the lane, grant = first pending index searching from ptr+1 with wrap at drvrs. Latch grant into src; set ptr = grant; go POP. Otherwise stay.
  - POP: assert pop[src] for exactly one cycle. Capture D_pop[src] into the lane data register. Go PUSH.
  - PUSH: decode dest = data[pckg_sz-1 -: 8].
    - dest < drvrs: push[dest]=1 for one cycle.
    - dest == broadcast: push[i]=1 for all i != src.
    - Otherwise: no push, packet dropped.
    - dest == src is legal and delivered.
    - D_push of every driver on the lane = data register (held until the next PUSH). Go IDLE.
- Latency: pndng sampled high in IDLE at edge N → pop high in cycle N+1 → push high in cycle N+2. One packet per lane per 3 cycles max.
- pndng is sampled only in IDLE; changes in POP/PUSH are ignored until the lane returns to IDLE.
- Fairness: the granted driver has lowest priority next round. With all drivers pending, grants cycle 0,1,..,drvrs-1,0.
- Lanes are fully independent; no shared state or cross-lane arbitration.
- Reset mid-operation: any pending pop/push is abandoned immediately; an in-flight packet already popped is lost. Verification must not expect it.
- busy is high in POP and PUSH.

Optional Feature:
- BUS_ARB_ERR_CNT_EN defined:
  - Adds output err_cnt, bits*16: per-lane saturating count of dropped (invalid-dest) packets.
  - Adds output err_flag, bits: sticky per-lane flag, set on the first drop.
  - Both reset to 0; err_cnt saturates at 16'hFFFF.
  - Increment occurs on the PUSH cycle.
- Not defined: drops are silent and both ports are absent.

Decomposition:
- Package bus_arb_pkg:
  - lane state enum {IDLE, POP, PUSH}.
  - ID_W=8.
  - Function get_dest(pkt) returning the top 8 bits.
  - Function rr_pick(req, ptr) returning next grant index.
- Sub-module bus_arb_lane: one FSM, pointer and data register for one bus.
  - Parameters drvrs, pckg_sz, broadcast.
- Top instantiates bits lanes via generate, slicing the flat port vectors.

Test Plan:
- Unicast: bits=1, drvrs=4. Driver 1 pending with D_pop=16'h0255 → pop[1] high one cycle, next cycle push[2]=1 only, D_push=16'h0255.
- Broadcast: driver 3 pending with 16'hFF12 → push=4'b0111 for one cycle, D_push=16'hFF12; push[3] stays low.
- Round-robin: all 4 drivers hold pndng=1 for 12 packets → pop order 0,1,2,3,0,1,2,3,0,1,2,3; each push 3 cycles apart.
- Invalid dest: driver 0 sends 16'h0711 → pop[0] fires, no push. With BUS_ARB_ERR_CNT_EN: err_cnt=1 and err_flag=1.
- Reset mid-op: drop reset during POP → pop, push and busy go 0 immediately. After release, driver 0 is granted first.
- Multi-bus (bits=2): simultaneous packets on lanes 0 and 1 with different dests → both lanes push in the same cycle, no interference.
